// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU-control opcodes, slice function codes and sequencer states
package alu_ctrl_pkg;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [1:0] F_AND   = 2'b00;
    localparam logic [1:0] F_OR    = 2'b01;
    localparam logic [1:0] F_SUM   = 2'b10;
    localparam logic [1:0] F_PASSB = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/ALU_1_Bit.sv
// ALU_1_Bit: one-bit MIPS ALU slice; select = {a_invert, b_invert, function[1:0]}
module ALU_1_Bit
    import alu_ctrl_pkg::*;
(
    input  logic       A,
    input  logic       B,
    input  logic       Cin,
    input  logic [3:0] select,
    output logic       O,
    output logic       Co
);
    logic a_i, b_i;
    assign a_i = A ^ select[3];
    assign b_i = B ^ select[2];
    assign Co  = (a_i & b_i) | (a_i & Cin) | (b_i & Cin);
    always_comb
        O = (select[1:0] == F_AND) ? (a_i & b_i) :
            (select[1:0] == F_OR)  ? (a_i | b_i) :
            (select[1:0] == F_SUM) ? (a_i ^ b_i ^ Cin) : b_i;
endmodule

// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer: bit-serial ALU, one ALU_1_Bit slice reused LSB first over WIDTH cycles
module alu_serial_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);
    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               carry, o, co, accept, last, is_slt;
    logic [WIDTH-1:0]   a_sh, b_sh, res_sh, res_n;
    logic [3:0]         op_q, sel;

    ALU_1_Bit u_slice (
        .A      (a_sh[0]),
        .B      (b_sh[0]),
        .Cin    (carry),
        .select (sel),
        .O      (o),
        .Co     (co)
    );

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign is_slt = (op_q == OP_SLT);
    assign ready  = (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_comb begin
        state_n = state;
        state_n = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    // On the last bit, carry holds the MSB carry-in and co the MSB carry-out
    assign res_n = is_slt ? {{(WIDTH-1){1'b0}}, o ^ carry ^ co} : {o, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            carry     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_q      <= '0;
            sel       <= '0;
            result    <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= op;
            sel   <= (op == OP_SLT) ? OP_SUB : op;
            carry <= op[2];
            cnt   <= '0;
        end else if (state == RUN) begin
            carry  <= co;
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {o, res_sh[WIDTH-1:1]};
            cnt    <= last ? cnt : cnt + 1'b1;
            if (last) begin
                result    <= res_n;
                zero      <= (res_n == '0);
                overflow  <= (op_q == OP_ADD || op_q == OP_SUB) ? (carry ^ co) : 1'b0;
                carry_out <= (sel[1:0] == F_SUM && !is_slt) ? co : 1'b0;
            end
        end
    end
endmodule
